am_align_ctrl: RTL

Multi-lane alignment controller sitting above the per-lane alignment-marker lock blocks and below the deskew FIFOs in the 40G receive PCS. It serialises the lanes' block-slip requests onto the shared gearbox slip path, checks that the logical-lane mapping reported by the lock blocks is a valid permutation, measures inter-lane arrival skew of alignment markers, and programs per-lane deskew delays. It then raises `align_status_o` and keeps checking the skew on every marker period.

---
 rtl/am_align_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/am_align_ctrl.sv
// Multi-lane alignment controller for the 40G receive PCS: serialises slip requests,
// validates the logical-lane map, measures marker skew and programs per-lane deskew delays.
module am_align_ctrl #(
  parameter int unsigned LANE_N    = 4,
  parameter int unsigned LANE_W    = 2,
  parameter int unsigned SKEW_MAX  = 15,
  parameter int unsigned SKEW_W    = 4,
  parameter int unsigned SLIP_HOLD = 3
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic                       valid_i,
  input  logic [LANE_N-1:0]          lock_v_i,
  input  logic [LANE_N-1:0]          am_v_i,
  input  logic [LANE_N*LANE_N-1:0]   lane_i,
  input  logic [LANE_N-1:0]          slip_req_i,
  output logic [LANE_N-1:0]          slip_o,
  output logic [LANE_N*SKEW_W-1:0]   delay_o,
  output logic [LANE_N*LANE_W-1:0]   lane_map_o,
  output logic                       align_status_o,
  output logic                       deskew_err_o
);

  localparam int unsigned HOLD_W = (SLIP_HOLD < 2) ? 1 : $clog2(SLIP_HOLD + 1);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_CHECK   = 2'd1;
  localparam logic [1:0] ST_DESKEW  = 2'd2;
  localparam logic [1:0] ST_ALIGNED = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [LANE_W-1:0]         ptr_q, ptr_d;
  logic [HOLD_W-1:0]         hold_q, hold_d;
  logic [LANE_N-1:0]         slip_q, slip_d;
  logic [LANE_N*SKEW_W-1:0]  delay_q, delay_d;
  logic [LANE_N*LANE_W-1:0]  map_q, map_d;
  logic [LANE_N*LANE_N-1:0]  snap_q, snap_d;
  logic [LANE_N*SKEW_W-1:0]  ref_q, ref_d;
  logic [LANE_N*SKEW_W-1:0]  off_q, off_d;
  logic [LANE_N-1:0]         seen_q, seen_d;
  logic [SKEW_W-1:0]         cnt_q, cnt_d;
  logic                      run_q, run_d;
  logic                      align_q, align_d;
  logic                      err_q, err_d;
  logic                      clr;

  logic [LANE_N-1:0]         grant_c;
  logic [LANE_W-1:0]         gidx_c;
  logic [LANE_W-1:0]         idx;
  logic                      found;
  logic                      grant_v_c;

  logic [LANE_N-1:0]         lor_c;
  logic                      onehot_c;
  logic                      map_ok_c;
  logic [LANE_N*LANE_W-1:0]  map_c;

  logic [LANE_N*SKEW_W-1:0]  off_n_c;
  logic [LANE_N-1:0]         seen_n_c;
  logic [SKEW_W-1:0]         cnt_n_c;
  logic                      run_n_c;
  logic                      meas_err_c;
  logic                      meas_done_c;
  logic [SKEW_W-1:0]         max_c;
  logic [LANE_N*SKEW_W-1:0]  delay_c;

  // Round-robin slip arbiter: first requester at or after the pointer, outside hold-off.
  always_comb begin
    grant_c = '0;
    gidx_c  = '0;
    idx     = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(LANE_N); k++) begin
      idx = LANE_W'((int'(ptr_q) + k) % int'(LANE_N));
      if (!found && slip_req_i[idx]) begin
        found   = 1'b1;
        gidx_c  = idx;
        grant_c = '0;
        grant_c[idx] = 1'b1;
      end
    end
    grant_v_c = valid_i && (hold_q == '0) && found;
  end

  // Lane map is valid only as a full permutation of one-hot ids.
  always_comb begin
    lor_c    = '0;
    onehot_c = 1'b1;
    map_c    = '0;
    for (int p = 0; p < int'(LANE_N); p++) begin
      lor_c = lor_c | lane_i[p*LANE_N +: LANE_N];
      if (!$onehot(lane_i[p*LANE_N +: LANE_N])) onehot_c = 1'b0;
      for (int j = 0; j < int'(LANE_N); j++) begin
        if (lane_i[p*LANE_N + j]) map_c[j*LANE_W +: LANE_W] = LANE_W'(p);
      end
    end
    map_ok_c = onehot_c && (&lor_c);
  end

  // One marker round: offset 0 is the first cycle with any marker.
  always_comb begin
    off_n_c     = off_q;
    seen_n_c    = seen_q;
    cnt_n_c     = cnt_q;
    run_n_c     = run_q;
    meas_err_c  = 1'b0;
    meas_done_c = 1'b0;
    max_c       = '0;
    delay_c     = '0;
    if (valid_i) begin
      if (!run_q) begin
        if (|am_v_i) begin
          run_n_c  = 1'b1;
          cnt_n_c  = SKEW_W'(1);
          seen_n_c = am_v_i;
        end
      end else begin
        if (|(am_v_i & seen_q)) meas_err_c = 1'b1;
        seen_n_c = seen_q | am_v_i;
        for (int p = 0; p < int'(LANE_N); p++) begin
          if (am_v_i[p] && !seen_q[p]) off_n_c[p*SKEW_W +: SKEW_W] = cnt_q;
        end
        if ((cnt_q == SKEW_W'(SKEW_MAX)) && !(&seen_n_c)) meas_err_c = 1'b1;
        cnt_n_c = cnt_q + SKEW_W'(1);
      end
      meas_done_c = (&seen_n_c) && !meas_err_c;
    end
    for (int p = 0; p < int'(LANE_N); p++) begin
      if (off_n_c[p*SKEW_W +: SKEW_W] > max_c) max_c = off_n_c[p*SKEW_W +: SKEW_W];
    end
    for (int p = 0; p < int'(LANE_N); p++) begin
      delay_c[p*SKEW_W +: SKEW_W] = max_c - off_n_c[p*SKEW_W +: SKEW_W];
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    slip_d  = '0;
    delay_d = delay_q;
    map_d   = map_q;
    snap_d  = snap_q;
    ref_d   = ref_q;
    off_d   = off_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    err_d   = 1'b0;
    clr     = 1'b0;

    if (grant_v_c) begin
      slip_d = grant_c;
      hold_d = HOLD_W'(SLIP_HOLD);
      ptr_d  = (gidx_c == LANE_W'(LANE_N - 1)) ? '0 : gidx_c + LANE_W'(1);
    end else if (valid_i && (hold_q != '0)) begin
      hold_d = hold_q - HOLD_W'(1);
    end

    if (valid_i) begin
      case (state_q)
        ST_WAIT: begin
          if (&lock_v_i) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (!(&lock_v_i)) begin
            state_d = ST_WAIT;
          end else if (map_ok_c) begin
            map_d   = map_c;
            snap_d  = lane_i;
            state_d = ST_DESKEW;
          end else begin
            err_d   = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: begin
          run_d  = run_n_c;
          cnt_d  = cnt_n_c;
          seen_d = seen_n_c;
          off_d  = off_n_c;
          // Lock loss, slips and remaps take precedence over any measurement outcome.
          if (!(&lock_v_i) || grant_v_c || ((state_q == ST_ALIGNED) && (lane_i != snap_q))) begin
            state_d = ST_WAIT;
            clr     = 1'b1;
          end else if (meas_err_c) begin
            err_d   = 1'b1;
            state_d = ST_WAIT;
            clr     = 1'b1;
          end else if (meas_done_c) begin
            clr = 1'b1;
            if (state_q == ST_DESKEW) begin
              delay_d = delay_c;
              ref_d   = off_n_c;
              state_d = ST_ALIGNED;
            end else if (off_n_c != ref_q) begin
              err_d   = 1'b1;
              state_d = ST_WAIT;
            end
          end
        end
      endcase
    end

    if (clr) begin
      run_d  = 1'b0;
      cnt_d  = '0;
      seen_d = '0;
      off_d  = '0;
    end
    align_d = (state_d == ST_ALIGNED);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_WAIT;
      ptr_q   <= '0;
      hold_q  <= '0;
      slip_q  <= '0;
      delay_q <= '0;
      map_q   <= '0;
      snap_q  <= '0;
      ref_q   <= '0;
      off_q   <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      align_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      slip_q  <= slip_d;
      delay_q <= delay_d;
      map_q   <= map_d;
      snap_q  <= snap_d;
      ref_q   <= ref_d;
      off_q   <= off_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      align_q <= align_d;
      err_q   <= err_d;
    end
  end

  assign slip_o         = slip_q;
  assign delay_o        = delay_q;
  assign lane_map_o     = map_q;
  assign align_status_o = align_q;
  assign deskew_err_o   = err_q;

endmodule
